// File: rtl/axi_lite_ctrl_regs_mc.sv
// axi_lite_ctrl_regs_mc: AXI4-Lite control/status slave for NUM_CH convolution cores.
// Map: 0x00 REVISION, 0x04 GCTRL, 0x08 IRQ_STAT (W1C), 0x0C IRQ_EN, then one 16-byte
// block per channel at 0x10+0x10*n: CH_CTRL, CH_STAT, DMA_ADDR, reserved.
// Optional build macro CTRL_REGS_DONE_CNT_EN adds a saturating done counter in CH_STAT[31:16].
module axi_lite_ctrl_regs_mc #(
  parameter logic [31:0] REVISION           = 32'h20200301,
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  output logic [1:0]                        S_AXI_BRESP,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              IRQ_out,
  output logic [NUM_CH-1:0]                 ch_start,
  output logic [NUM_CH-1:0]                 ch_load_param,
  output logic [NUM_CH-1:0]                 ch_frm_is_ref,
  output logic [NUM_CH-1:0]                 ch_frm_is_diff,
  output logic [NUM_CH*8-1:0]               ch_frm_index,
  output logic [NUM_CH*32-1:0]              ch_dma_addr,
  input  logic [NUM_CH-1:0]                 ch_done
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // write channel state
  logic                          awready, wready, bvalid;
  logic [1:0]                    bresp;
  logic                          aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]                   w_data;
  logic [3:0]                    w_strb;
  logic [31:0]                   wmask;

  // read channel state
  logic                          arready, rvalid;
  logic [1:0]                    rresp;
  logic [31:0]                   rdata;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [31:0]                   rd_val;
  logic                          rd_err;
  logic [31:0]                   rd_blk;

  // write decode
  logic                          wr_en, wr_ok;
  logic [31:0]                   wr_blk;
  logic                          gctrl_we, irq_en_we;
  logic [NUM_CH-1:0]             stat_clr;
  logic [NUM_CH-1:0]             ctrl_we, stat_we, dma_we;

  // register file
  logic                          gctrl_ie;
  logic [NUM_CH-1:0]             irq_stat, irq_en;
  logic                          irq_q;
  logic [NUM_CH-1:0]             start_q, load_q, busy, overrun;
  logic [NUM_CH-1:0]             frm_ref, frm_diff;
  logic [7:0]                    frm_index [NUM_CH];
  logic [31:0]                   dma_addr  [NUM_CH];
`ifdef CTRL_REGS_DONE_CNT_EN
  logic [15:0]                   done_cnt  [NUM_CH];
`endif

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], ar_addr[1:0]};

  assign S_AXI_AWREADY  = awready;
  assign S_AXI_WREADY   = wready;
  assign S_AXI_BVALID   = bvalid;
  assign S_AXI_BRESP    = bresp;
  assign S_AXI_ARREADY  = arready;
  assign S_AXI_RVALID   = rvalid;
  assign S_AXI_RDATA    = rdata;
  assign S_AXI_RRESP    = rresp;
  assign IRQ_out        = irq_q;
  assign ch_start       = start_q;
  assign ch_load_param  = load_q;
  assign ch_frm_is_ref  = frm_ref;
  assign ch_frm_is_diff = frm_diff;

  // expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      wmask[b*8 +: 8] = {8{w_strb[b]}};
    end
  end

  // write decode: 16-byte block 0 is global, block n+1 is channel n
  always_comb begin
    wr_blk    = 32'(aw_addr) >> 4;
    wr_en     = aw_held && w_held && !bvalid;
    wr_ok     = (wr_blk <= NUM_CH);
    gctrl_we  = wr_en && (wr_blk == 32'd0) && (aw_addr[3:2] == 2'd1);
    irq_en_we = wr_en && (wr_blk == 32'd0) && (aw_addr[3:2] == 2'd3);
    stat_clr  = '0;
    if (wr_en && (wr_blk == 32'd0) && (aw_addr[3:2] == 2'd2)) begin
      stat_clr = w_data[NUM_CH-1:0] & wmask[NUM_CH-1:0];
    end
    ctrl_we = '0;
    stat_we = '0;
    dma_we  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      ctrl_we[n] = wr_en && (wr_blk == n + 1) && (aw_addr[3:2] == 2'd0);
      stat_we[n] = wr_en && (wr_blk == n + 1) && (aw_addr[3:2] == 2'd1);
      dma_we[n]  = wr_en && (wr_blk == n + 1) && (aw_addr[3:2] == 2'd2);
    end
  end

  // AW/W capture, commit and B response handshake
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      awready <= S_AXI_AWVALID && !aw_held && !awready;
      wready  <= S_AXI_WVALID && !w_held && !wready;
      if (awready && S_AXI_AWVALID) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (wready && S_AXI_WVALID) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (wr_en) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // read data mux from the latched read address
  always_comb begin
    rd_blk = 32'(ar_addr) >> 4;
    rd_val = '0;
    rd_err = 1'b0;
    if (rd_blk == 32'd0) begin
      case (ar_addr[3:2])
        2'd0: rd_val = REVISION;
        2'd1: rd_val = {31'b0, gctrl_ie};
        2'd2: rd_val = 32'(irq_stat);
        2'd3: rd_val = 32'(irq_en);
      endcase
    end else if (rd_blk <= NUM_CH) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (rd_blk == n + 1) begin
          case (ar_addr[3:2])
            2'd0: rd_val = {16'b0, frm_index[n], 2'b0, frm_diff[n], frm_ref[n], 4'b0};
`ifdef CTRL_REGS_DONE_CNT_EN
            2'd1: rd_val = {done_cnt[n], 14'b0, overrun[n], busy[n]};
`else
            2'd1: rd_val = {30'b0, overrun[n], busy[n]};
`endif
            2'd2: rd_val = dma_addr[n];
            2'd3: rd_val = '0;
          endcase
        end
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  // AR capture and R response handshake; address latched when ARREADY is raised
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      ar_addr <= '0;
    end else begin
      arready <= 1'b0;
      if (S_AXI_ARVALID && !arready && !rvalid) begin
        arready <= 1'b1;
        ar_addr <= S_AXI_ARADDR;
      end
      if (arready && S_AXI_ARVALID) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // global registers and interrupt; a done pulse wins over a same-cycle W1C
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      gctrl_ie <= 1'b0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (gctrl_we && w_strb[0]) gctrl_ie <= w_data[0];
      if (irq_en_we) begin
        irq_en <= (irq_en & ~wmask[NUM_CH-1:0]) | (w_data[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
      end
      irq_stat <= (irq_stat & ~stat_clr) | ch_done;
      irq_q    <= (|(irq_stat & irq_en)) & gctrl_ie;
    end
  end

  // per-channel control, busy/overrun tracking and DMA address
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      start_q  <= '0;
      load_q   <= '0;
      busy     <= '0;
      overrun  <= '0;
      frm_ref  <= '0;
      frm_diff <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        frm_index[n] <= '0;
        dma_addr[n]  <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        start_q[n] <= 1'b0;
        load_q[n]  <= 1'b0;
        if (ctrl_we[n] && w_strb[0]) begin
          frm_ref[n]  <= w_data[4];
          frm_diff[n] <= w_data[5];
          load_q[n]   <= w_data[1];
        end
        if (ctrl_we[n] && w_strb[1]) frm_index[n] <= w_data[15:8];
        if (ctrl_we[n] && w_strb[0] && w_data[0] && !busy[n]) begin
          start_q[n] <= 1'b1;
          busy[n]    <= 1'b1;
        end else if (ch_done[n]) begin
          busy[n] <= 1'b0;
        end
        if (ctrl_we[n] && w_strb[0] && w_data[0] && busy[n]) begin
          overrun[n] <= 1'b1;
        end else if (stat_we[n] && w_strb[0] && w_data[1]) begin
          overrun[n] <= 1'b0;
        end
        if (dma_we[n]) dma_addr[n] <= (dma_addr[n] & ~wmask) | (w_data & wmask);
      end
    end
  end

`ifdef CTRL_REGS_DONE_CNT_EN
  // saturating per-channel done counters; a clear in the same cycle as a done leaves 1
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned n = 0; n < NUM_CH; n++) done_cnt[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (stat_we[n] && (w_strb[3:2] == 2'b11) && (w_data[31:16] == 16'hFFFF)) begin
          done_cnt[n] <= ch_done[n] ? 16'd1 : 16'd0;
        end else if (ch_done[n] && (done_cnt[n] != '1)) begin
          done_cnt[n] <= done_cnt[n] + 16'd1;
        end
      end
    end
  end
`endif

  // pack per-channel fields onto the flat output buses
  always_comb begin
    ch_frm_index = '0;
    ch_dma_addr  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      ch_frm_index[n*8 +: 8] = frm_index[n];
      ch_dma_addr[n*32 +: 32] = dma_addr[n];
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_regs_mc.sv
// Directed bench for axi_lite_ctrl_regs_mc (NUM_CH=4). Honours CTRL_REGS_DONE_CNT_EN.
module tb_axi_lite_ctrl_regs_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         irq;
  logic [3:0]   ch_start, ch_load_param, ch_frm_is_ref, ch_frm_is_diff, ch_done;
  logic [31:0]  ch_frm_index;
  logic [127:0] ch_dma_addr;

  int checks   = 0;
  int failures = 0;
  int start_cnt0 = 0;
  int load_cnt0  = 0;

  always #5 clk = ~clk;

  axi_lite_ctrl_regs_mc #(
    .REVISION(32'h20200301),
    .NUM_CH(4),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(8)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .IRQ_out(irq), .ch_start(ch_start), .ch_load_param(ch_load_param),
    .ch_frm_is_ref(ch_frm_is_ref), .ch_frm_is_diff(ch_frm_is_diff),
    .ch_frm_index(ch_frm_index), .ch_dma_addr(ch_dma_addr), .ch_done(ch_done)
  );

  // count channel-0 pulse cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (ch_start[0]) start_cnt0++;
    if (ch_load_param[0]) load_cnt0++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW issued first, W after w_delay cycles; done_mask driven in the commit cycle
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input logic [3:0] done_mask,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hs, w_hs;
    awvalid = 1'b1;
    awaddr  = addr;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == w_delay) begin
        wvalid = 1'b1;
        wdata  = data;
        wstrb  = strb;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    ch_done = done_mask;
    do begin
      tick();
      ch_done = '0;
      lat++;
    end while (!bvalid && lat < 40);
    resp = bresp;
    if (!bvalid) check("bvalid_timeout", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n = 0;
    arvalid = 1'b1;
    araddr  = addr;
    do begin
      hs = arready;
      tick();
      n++;
    end while (!hs && n < 40);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin
      tick();
      n++;
    end
    if (!rvalid) check("rvalid_timeout", 32'(rvalid), 32'd1);
    data  = rdata;
    resp  = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] mask, input int count);
    for (int i = 0; i < count; i++) begin
      ch_done = mask;
      tick();
      ch_done = '0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int lat;
    int s0, l0;
    rst_n = 1'b0;
    awvalid = 0; awaddr = '0; awprot = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; arprot = '0; rready = 0; ch_done = '0;
    repeat (3) tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hs", {28'b0, awready, wready, bvalid, rvalid}, 32'd0);
    check("rst_dma", ch_dma_addr[31:0], 32'd0);
    check("rst_ctrl", {ch_start, ch_load_param, ch_frm_is_ref, ch_frm_is_diff, ch_frm_index[15:0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    axi_read(8'h00, rd, rsp);
    check("rev", rd, 32'h20200301);
    check("rev_resp", 32'(rsp), 32'd0);
    axi_read(8'h04, rd, rsp); check("gctrl_rst", rd, 32'd0);
    axi_read(8'h08, rd, rsp); check("istat_rst", rd, 32'd0);
    axi_read(8'h0C, rd, rsp); check("ien_rst", rd, 32'd0);

    axi_write(8'h18, 32'hDEADBEEF, 4'hF, 3, 4'h0, rsp, lat);
    check("dma_lat", 32'(lat), 32'd2);
    check("dma_bresp", 32'(rsp), 32'd0);
    check("dma_port", ch_dma_addr[31:0], 32'hDEADBEEF);
    axi_read(8'h18, rd, rsp); check("dma_rb", rd, 32'hDEADBEEF);

    s0 = start_cnt0; l0 = load_cnt0;
    axi_write(8'h10, 32'h0000_0531, 4'hF, 0, 4'h0, rsp, lat);
    check("start_pulse", 32'(start_cnt0 - s0), 32'd1);
    check("start_noload", 32'(load_cnt0 - l0), 32'd0);
    check("frm_index", {24'b0, ch_frm_index[7:0]}, 32'h05);
    check("frm_bits", {30'b0, ch_frm_is_diff[0], ch_frm_is_ref[0]}, 32'h3);
    axi_read(8'h14, rd, rsp); check("busy", rd, 32'h1);
    s0 = start_cnt0;
    axi_write(8'h10, 32'h0000_0531, 4'hF, 0, 4'h0, rsp, lat);
    check("restart_nopulse", 32'(start_cnt0 - s0), 32'd0);
    axi_read(8'h14, rd, rsp); check("overrun", rd, 32'h3);
    l0 = load_cnt0;
    axi_write(8'h10, 32'h0000_0532, 4'hF, 0, 4'h0, rsp, lat);
    check("load_pulse", 32'(load_cnt0 - l0), 32'd1);
    axi_read(8'h10, rd, rsp); check("ctrl_rb", rd, 32'h0000_0530);

    axi_write(8'h0C, 32'h1, 4'hF, 0, 4'h0, rsp, lat);
    axi_write(8'h04, 32'h1, 4'hF, 0, 4'h0, rsp, lat);
    ch_done = 4'h1;
    tick();
    ch_done = '0;
    check("irq_lat1", 32'(irq), 32'd0);
    tick();
    check("irq_lat2", 32'(irq), 32'd1);
    axi_read(8'h08, rd, rsp); check("istat_set", rd, 32'h1);
    axi_read(8'h14, rd, rsp); check("busy_clr", rd, 32'h2);
    axi_write(8'h08, 32'h1, 4'hF, 0, 4'h0, rsp, lat);
    axi_read(8'h08, rd, rsp); check("w1c", rd, 32'h0);
    check("irq_drop", 32'(irq), 32'd0);
    axi_write(8'h08, 32'h1, 4'hF, 0, 4'h1, rsp, lat);
    axi_read(8'h08, rd, rsp); check("w1c_vs_done", rd, 32'h1);

    s0 = start_cnt0;
    axi_write(8'h50, 32'hFFFF_FFFF, 4'hF, 0, 4'h0, rsp, lat);
    check("unmap_bresp", 32'(rsp), 32'd2);
    axi_read(8'h50, rd, rsp);
    check("unmap_rresp", 32'(rsp), 32'd2);
    check("unmap_rdata", rd, 32'd0);
    check("unmap_nochg", ch_dma_addr[31:0], 32'hDEADBEEF);
    check("unmap_nostart", 32'(start_cnt0 - s0), 32'd0);
    axi_read(8'h4C, rd, rsp);
    check("resv_rresp", 32'(rsp), 32'd0);
    check("resv_rdata", rd, 32'd0);

    axi_write(8'h28, 32'h11223344, 4'hF, 0, 4'h0, rsp, lat);
    axi_write(8'h28, 32'h0000_AB00, 4'b0010, 0, 4'h0, rsp, lat);
    axi_read(8'h28, rd, rsp); check("wstrb", rd, 32'h1122AB44);
    check("wstrb_port", ch_dma_addr[63:32], 32'h1122AB44);

    pulse_done(4'h2, 3);
    axi_read(8'h08, rd, rsp); check("istat_ch1", rd, 32'h3);
    axi_read(8'h24, rd, rsp);
`ifdef CTRL_REGS_DONE_CNT_EN
    check("done_cnt", rd, 32'h0003_0000);
    axi_write(8'h24, 32'hFFFF_0000, 4'b1100, 0, 4'h0, rsp, lat);
    axi_read(8'h24, rd, rsp); check("done_cnt_clr", rd, 32'h0);
`else
    check("done_cnt_off", rd, 32'h0);
`endif

    awvalid = 1'b1; awaddr = 8'h18; wvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF;
    tick();
    check("mid_awready", 32'(awready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hs", {30'b0, awready, wready}, 32'd0);
    check("mid_rst_dma", ch_dma_addr[31:0], 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    axi_read(8'h08, rd, rsp); check("post_rst_istat", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
